decode_unit: RTL and testbench
==============================

DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 The block SHALL have no parameters; XLEN is fixed at 32 and the register count at 32.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset.
REQ-003 CLK  in  1  rising-edge clock for register-file writes.
REQ-004 RSTn  in  1  asynchronous active-low reset.
REQ-005 EN  in  1  write enable qualifier; the register file writes only when EN=1.
REQ-006 instr  in  32  RV32I instruction being decoded.
REQ-007 wb_rd  in  5  write-back destination register index.
REQ-008 wb_data  in  32  write-back data.
REQ-009 wb_reg_write  in  1  write-back write request.
REQ-010 rs1, rs2, rd  out  5 each  decoded register indices.
REQ-011 rd_nz  out  1  rd-nonzero flag; 1 when rd != 0.
REQ-012 reg_data1, reg_data2  out  32 each  register read data.
REQ-013 imm  out  32  sign-extended immediate.
REQ-014 reg_write  out  1  control signal.
REQ-015 wb_sel  out  2  write-back select: 00 = ALU, 01 = memory, 10 = PC+4.
REQ-016 mem_read, mem_write, branch, jump  out  1 each  control signals.
REQ-017 alu_src_a  out  1  ALU operand A select: 1 = PC.
REQ-018 alu_src_b  out  1  ALU operand B select: 1 = imm.
REQ-019 alu_op  out  2  ALU operation class.
REQ-020 alu_ctrl  out  4  equal to {instr[30], instr[14:12]}.
REQ-021 illegal_instr, mret_detected  out  1 each  trap and MRET flags.

Function
REQ-022 Decode, immediate generation and register reads SHALL be purely combinational with zero latency.
REQ-023 rs2 SHALL equal instr[24:20] and rd SHALL equal instr[11:7].
REQ-024 rs1 SHALL equal instr[19:15], except when instr[6:2]=01101 (LUI), where rs1 SHALL be 0.
REQ-025 A read of index 0 SHALL return 0 regardless of stored state or bypass.
REQ-026 On a CLK rising edge with RSTn=1, EN=1, wb_reg_write=1 and wb_rd!=0, the register file SHALL write wb_data to register wb_rd.
REQ-027 Writes to x0 SHALL be ignored.
REQ-028 Immediate formats by opcode:
- I-type (LOAD, OP-IMM, JALR, SYSTEM): {20{i[31]}, i[31:20]}.
- S-type: {20{i[31]}, i[31:25], i[11:7]}.
- B-type: {19{i[31]}, i[31], i[7], i[30:25], i[11:8], 0}.
- U-type (LUI, AUIPC): {i[31:12], 12'b0}.
- J-type: {11{i[31]}, i[31], i[19:12], i[20], i[30:21], 0}.
- R-type and illegal: 0.
REQ-029 Control decode by opcode:
- OP: reg_write=1, alu_op=10.
- OP-IMM: reg_write=1, alu_src_b=1, alu_op=11.
- LOAD: reg_write=1, mem_read=1, wb_sel=01, alu_src_b=1, alu_op=00.
- STORE: mem_write=1, alu_src_b=1, alu_op=00.
- BRANCH: branch=1, alu_op=01.
- JAL: jump=1, reg_write=1, wb_sel=10, alu_src_a=1, alu_src_b=1.
- JALR: jump=1, reg_write=1, wb_sel=10, alu_src_b=1.
- LUI: reg_write=1, alu_src_b=1, alu_op=00.
- AUIPC: reg_write=1, alu_src_a=1, alu_src_b=1, alu_op=00.
- Every control output not listed for a given opcode SHALL be 0.
REQ-030 illegal_instr SHALL be 1 for any of the following:
- instr[1:0]!=11;
- an unlisted opcode;
- OP with funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101;
- BRANCH with funct3 010/011;
- LOAD with funct3 011/110/111;
- STORE with funct3 >010;
- SYSTEM other than MRET.
REQ-031 While illegal_instr=1, every control output except alu_ctrl SHALL be 0.
REQ-032 mret_detected SHALL be 1 iff instr=0x30200073; MRET SHALL NOT be flagged illegal and SHALL produce all-zero control.

Reset
REQ-033 RSTn=0 SHALL asynchronously clear all 32 registers to 0.
REQ-034 Reset SHALL dominate a simultaneous write.
REQ-035 The decode outputs SHALL remain combinational functions of instr during reset; there is no other stored state.

Configuration
REQ-036 With macro RF_WB_BYPASS_EN defined, a read of index r!=0 SHALL return wb_data combinationally when wb_reg_write=1 and wb_rd=r, giving write-before-read in the same cycle.
REQ-037 Without RF_WB_BYPASS_EN, reads SHALL return only the stored value, and the new value SHALL be visible from the cycle after the write edge.

Verification
REQ-038 Assert RSTn=0, then release it; set instr=0x00500033 -> reg_data1=0, reg_data2=0.
REQ-039 Write x5=0xDEADBEEF with EN=1 and wb_reg_write=1, then wb_reg_write=0 and instr with rs1=5 -> reg_data1=0xDEADBEEF; write x0=0x1 -> reading x0 returns 0.
REQ-040 With RF_WB_BYPASS_EN, wb_rd=7, wb_data=0x12345678, wb_reg_write=1 and rs2=7 in the same cycle -> reg_data2=0x12345678 before the edge; without the macro -> the old value.
REQ-041 instr=0xFFC10113 -> imm=0xFFFFFFFC, rs1=2, rd=2, reg_write=1, alu_src_b=1, alu_op=11, illegal_instr=0.
REQ-042 instr=0x123450B7 -> imm=0x12345000, rs1=0, rd=1, reg_write=1.
REQ-043 instr=0x30200073 -> mret_detected=1, illegal_instr=0; instr=0xFFFFFFFF -> illegal_instr=1 with reg_write=mem_write=mem_read=0.

Source files
------------

// File: rtl/decode_unit_if.sv
//------------------------------------------------------------------------------
// decode_unit_if
// Bundles the instruction, write-back and decoded-output signals of
// decode_unit.
//   master : the pipeline side; drives instr and the write-back bus,
//            receives register indices, read data, immediate and controls.
//   slave  : the decode unit itself.
// CLK, RSTn and EN stay plain ports on decode_unit.
//------------------------------------------------------------------------------
interface decode_unit_if;
   // Instruction and write-back bus
   logic [31:0] instr;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_reg_write;

   // Decoded register indices and read data
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic        rd_nz;
   logic [31:0] reg_data1;
   logic [31:0] reg_data2;
   logic [31:0] imm;

   // Control outputs
   logic        reg_write;
   logic [1:0]  wb_sel;
   logic        mem_read;
   logic        mem_write;
   logic        branch;
   logic        jump;
   logic        alu_src_a;
   logic        alu_src_b;
   logic [1:0]  alu_op;
   logic [3:0]  alu_ctrl;
   logic        illegal_instr;
   logic        mret_detected;

   modport master (
      output instr, wb_rd, wb_data, wb_reg_write,
      input  rs1, rs2, rd, rd_nz, reg_data1, reg_data2, imm,
      input  reg_write, wb_sel, mem_read, mem_write, branch, jump,
      input  alu_src_a, alu_src_b, alu_op, alu_ctrl, illegal_instr, mret_detected
   );

   modport slave (
      input  instr, wb_rd, wb_data, wb_reg_write,
      output rs1, rs2, rd, rd_nz, reg_data1, reg_data2, imm,
      output reg_write, wb_sel, mem_read, mem_write, branch, jump,
      output alu_src_a, alu_src_b, alu_op, alu_ctrl, illegal_instr, mret_detected
   );
endinterface

// File: rtl/decode_unit.sv
//------------------------------------------------------------------------------
// decode_unit
// RV32I instruction decoder with a 32 x 32-bit register file.
// Decode, immediate generation and register reads are combinational; only
// the register file is clocked.
//
// Ports:
//   CLK   : rising-edge clock for register-file writes
//   RSTn  : asynchronous active-low reset, clears every register
//   EN    : write qualifier, the register file only writes when EN=1
//   bus   : decode_unit_if.slave (instr, write-back bus, decoded outputs)
//
// Build option:
//   RF_WB_BYPASS_EN : when defined, a read whose index matches an active
//                     write-back returns wb_data in the same cycle.
//------------------------------------------------------------------------------
module decode_unit (
   input  logic          CLK,
   input  logic          RSTn,
   input  logic          EN,
   decode_unit_if.slave  bus
);

   // Major opcode, instr[6:2] (instr[1:0] must be 2'b11)
   typedef enum logic [4:0] {
      OPC_LOAD   = 5'b00000,
      OPC_OP_IMM = 5'b00100,
      OPC_AUIPC  = 5'b00101,
      OPC_STORE  = 5'b01000,
      OPC_OP     = 5'b01100,
      OPC_LUI    = 5'b01101,
      OPC_BRANCH = 5'b11000,
      OPC_JALR   = 5'b11001,
      OPC_JAL    = 5'b11011,
      OPC_SYSTEM = 5'b11100
   } opcode_e;

   typedef enum logic [2:0] {
      IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
   } imm_fmt_e;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       alu_src_a;
      logic       alu_src_b;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam logic [31:0] MRET_INSTR = 32'h3020_0073;

   logic [31:0] instr;
   opcode_e     opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        is_mret;
   logic        legal;
   ctrl_t       ctrl;
   ctrl_t       ctrl_out;
   imm_fmt_e    imm_fmt;
   logic [4:0]  rs1_idx;
   logic [4:0]  rs2_idx;
   logic [31:0] regs [32];

   assign instr   = bus.instr;
   assign opcode  = opcode_e'(instr[6:2]);
   assign funct3  = instr[14:12];
   assign funct7  = instr[31:25];
   assign is_mret = (instr == MRET_INSTR);

   // LUI has no rs1 field; forcing 0 keeps spurious hazards off the bits
   assign rs1_idx = (opcode == OPC_LUI) ? 5'd0 : instr[19:15];
   assign rs2_idx = instr[24:20];

   //---------------------------------------------------------------------------
   // Opcode decode: raw controls, immediate format and legality
   //---------------------------------------------------------------------------
   // NOTE: every variable written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      ctrl    = '0;
      imm_fmt = IMM_NONE;
      legal   = 1'b0;
      if (instr[1:0] == 2'b11) begin
         case (opcode)
            OPC_OP: begin
               legal = (funct7 == 7'b0000000) ||
                       (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
               ctrl.reg_write = 1'b1;
               ctrl.alu_op    = 2'b10;
            end
            OPC_OP_IMM: begin
               legal          = 1'b1;
               imm_fmt        = IMM_I;
               ctrl.reg_write = 1'b1;
               ctrl.alu_src_b = 1'b1;
               ctrl.alu_op    = 2'b11;
            end
            OPC_LOAD: begin
               legal          = !(funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
               imm_fmt        = IMM_I;
               ctrl.reg_write = 1'b1;
               ctrl.mem_read  = 1'b1;
               ctrl.wb_sel    = 2'b01;
               ctrl.alu_src_b = 1'b1;
            end
            OPC_STORE: begin
               legal          = (funct3 <= 3'b010);
               imm_fmt        = IMM_S;
               ctrl.mem_write = 1'b1;
               ctrl.alu_src_b = 1'b1;
            end
            OPC_BRANCH: begin
               legal       = !(funct3 == 3'b010 || funct3 == 3'b011);
               imm_fmt     = IMM_B;
               ctrl.branch = 1'b1;
               ctrl.alu_op = 2'b01;
            end
            OPC_JAL: begin
               legal          = 1'b1;
               imm_fmt        = IMM_J;
               ctrl.jump      = 1'b1;
               ctrl.reg_write = 1'b1;
               ctrl.wb_sel    = 2'b10;
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = 1'b1;
            end
            OPC_JALR: begin
               legal          = 1'b1;
               imm_fmt        = IMM_I;
               ctrl.jump      = 1'b1;
               ctrl.reg_write = 1'b1;
               ctrl.wb_sel    = 2'b10;
               ctrl.alu_src_b = 1'b1;
            end
            OPC_LUI: begin
               legal          = 1'b1;
               imm_fmt        = IMM_U;
               ctrl.reg_write = 1'b1;
               ctrl.alu_src_b = 1'b1;
            end
            OPC_AUIPC: begin
               legal          = 1'b1;
               imm_fmt        = IMM_U;
               ctrl.reg_write = 1'b1;
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = 1'b1;
            end
            OPC_SYSTEM: begin
               // MRET is the only supported SYSTEM encoding; it carries no controls
               legal   = is_mret;
               imm_fmt = IMM_I;
            end
            default: legal = 1'b0;
         endcase
      end
   end

   // An illegal instruction must not trigger any side effect downstream
   assign ctrl_out = legal ? ctrl : '0;

   always_comb begin
      bus.imm = '0;
      if (legal) begin
         case (imm_fmt)
            IMM_I:   bus.imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   bus.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   bus.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   bus.imm = {instr[31:12], 12'b0};
            IMM_J:   bus.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: bus.imm = '0;
         endcase
      end
   end

   assign bus.rs1           = rs1_idx;
   assign bus.rs2           = rs2_idx;
   assign bus.rd            = instr[11:7];
   assign bus.rd_nz         = (instr[11:7] != 5'd0);
   assign bus.reg_write     = ctrl_out.reg_write;
   assign bus.wb_sel        = ctrl_out.wb_sel;
   assign bus.mem_read      = ctrl_out.mem_read;
   assign bus.mem_write     = ctrl_out.mem_write;
   assign bus.branch        = ctrl_out.branch;
   assign bus.jump          = ctrl_out.jump;
   assign bus.alu_src_a     = ctrl_out.alu_src_a;
   assign bus.alu_src_b     = ctrl_out.alu_src_b;
   assign bus.alu_op        = ctrl_out.alu_op;
   assign bus.alu_ctrl      = {instr[30], instr[14:12]};
   assign bus.illegal_instr = !legal;
   assign bus.mret_detected = is_mret;

   //---------------------------------------------------------------------------
   // Register file
   //---------------------------------------------------------------------------
   // NOTE: the array is cleared by an asynchronous reset, so it maps to
   // flip-flops rather than a RAM macro; that is intentional here.
   // NOTE: state is updated with non-blocking assignments so every clocked
   // process sees the pre-edge values, independent of evaluation order.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int k = 0; k < 32; k++) regs[k] <= '0;
      end else if (EN && bus.wb_reg_write && bus.wb_rd != 5'd0) begin
         regs[bus.wb_rd] <= bus.wb_data;
      end
   end

   function automatic logic [31:0] rf_read(input logic [4:0] idx);
      logic [31:0] val;
      if (idx == 5'd0) val = '0;
`ifdef RF_WB_BYPASS_EN
      else if (bus.wb_reg_write && bus.wb_rd == idx) val = bus.wb_data;
`endif
      else val = regs[idx];
      return val;
   endfunction

   always_comb begin
      bus.reg_data1 = rf_read(rs1_idx);
      bus.reg_data2 = rf_read(rs2_idx);
   end

endmodule

// File: tb/tb_decode_unit.sv
//------------------------------------------------------------------------------
// tb_decode_unit
// Self-checking bench for decode_unit: directed cases followed by random
// instructions and write-back traffic, compared against a behavioural model.
//------------------------------------------------------------------------------
module tb_decode_unit;

   logic CLK;
   logic RSTn;
   logic EN;

   decode_unit_if bus ();

   decode_unit dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .EN   (EN),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   //---------------------------------------------------------------------------
   // Behavioural model
   //---------------------------------------------------------------------------
   typedef struct packed {
      logic [31:0] imm;
      logic        reg_write;
      logic [1:0]  wb_sel;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        src_a;
      logic        src_b;
      logic [1:0]  alu_op;
      logic        illegal;
      logic        mret;
   } exp_t;

   localparam logic [31:0] MRET = 32'h3020_0073;

   logic [31:0] model_rf [32];

   // Register contents as the architecture defines them
   always @(posedge CLK)
      if (RSTn && EN && bus.wb_reg_write && bus.wb_rd != 5'd0)
         model_rf[bus.wb_rd] = bus.wb_data;

   always @(negedge RSTn)
      for (int k = 0; k < 32; k++) model_rf[k] = '0;

   function automatic logic [31:0] model_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
`ifdef RF_WB_BYPASS_EN
      if (bus.wb_reg_write && bus.wb_rd == idx) return bus.wb_data;
`endif
      return model_rf[idx];
   endfunction

   // Immediates computed as signed integers from the field values
   function automatic logic [31:0] imm_i(input logic [31:0] i);
      int v = int'(i[31:20]);
      if (i[31]) v -= 4096;
      return 32'(v);
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] i);
      int v = int'(i[31:25]) * 32 + int'(i[11:7]);
      if (i[31]) v -= 4096;
      return 32'(v);
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] i);
      int v = int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      if (i[31]) v -= 8192;
      return 32'(v);
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] i);
      int v = int'(i[31]) * (1 << 20) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      if (i[31]) v -= (1 << 21);
      return 32'(v);
   endfunction

   function automatic exp_t model_decode(input logic [31:0] i);
      exp_t e;
      logic [2:0] f3 = i[14:12];
      logic [6:0] f7 = i[31:25];
      logic bad;
      e = '0;
      bad = 1'b0;
      if (i[1:0] != 2'b11) bad = 1'b1;
      else begin
         case (i[6:0])
            7'b0110011: bad = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            7'b1100011: bad = (f3 == 3'd2 || f3 == 3'd3);
            7'b0000011: bad = (f3 == 3'd3 || f3 >= 3'd6);
            7'b0100011: bad = (f3 > 3'd2);
            7'b1110011: bad = (i != MRET);
            7'b0010011, 7'b0010111, 7'b0110111, 7'b1101111, 7'b1100111: bad = 1'b0;
            default:    bad = 1'b1;
         endcase
      end
      if (bad) begin
         e.illegal = 1'b1;
         return e;
      end
      e.mret = (i == MRET);
      case (i[6:0])
         7'b0110011: begin e.reg_write = 1; e.alu_op = 2'd2; end
         7'b0010011: begin e.reg_write = 1; e.src_b = 1; e.alu_op = 2'd3; e.imm = imm_i(i); end
         7'b0000011: begin e.reg_write = 1; e.mem_read = 1; e.wb_sel = 2'd1; e.src_b = 1; e.imm = imm_i(i); end
         7'b0100011: begin e.mem_write = 1; e.src_b = 1; e.imm = imm_s(i); end
         7'b1100011: begin e.branch = 1; e.alu_op = 2'd1; e.imm = imm_b(i); end
         7'b1101111: begin e.jump = 1; e.reg_write = 1; e.wb_sel = 2'd2; e.src_a = 1; e.src_b = 1; e.imm = imm_j(i); end
         7'b1100111: begin e.jump = 1; e.reg_write = 1; e.wb_sel = 2'd2; e.src_b = 1; e.imm = imm_i(i); end
         7'b0110111: begin e.reg_write = 1; e.src_b = 1; e.imm = i & 32'hFFFF_F000; end
         7'b0010111: begin e.reg_write = 1; e.src_a = 1; e.src_b = 1; e.imm = i & 32'hFFFF_F000; end
         default:    e.imm = imm_i(i);  // SYSTEM (MRET)
      endcase
      return e;
   endfunction

   // Compare every output against the model for the currently driven inputs
   task automatic compare_model();
      exp_t e = model_decode(bus.instr);
      logic [4:0] s1 = (bus.instr[6:0] == 7'b0110111 || bus.instr[6:2] == 5'b01101) ? 5'd0 : bus.instr[19:15];
      check("rs1",       bus.rs1,           s1);
      check("rs2",       bus.rs2,           bus.instr[24:20]);
      check("rd",        bus.rd,            bus.instr[11:7]);
      check("rd_nz",     bus.rd_nz,         bus.instr[11:7] != 0);
      check("reg_data1", bus.reg_data1,     model_read(s1));
      check("reg_data2", bus.reg_data2,     model_read(bus.instr[24:20]));
      check("imm",       bus.imm,           e.imm);
      check("reg_write", bus.reg_write,     e.reg_write);
      check("wb_sel",    bus.wb_sel,        e.wb_sel);
      check("mem_read",  bus.mem_read,      e.mem_read);
      check("mem_write", bus.mem_write,     e.mem_write);
      check("branch",    bus.branch,        e.branch);
      check("jump",      bus.jump,          e.jump);
      check("alu_src_a", bus.alu_src_a,     e.src_a);
      check("alu_src_b", bus.alu_src_b,     e.src_b);
      check("alu_op",    bus.alu_op,        e.alu_op);
      check("alu_ctrl",  bus.alu_ctrl,      {bus.instr[30], bus.instr[14:12]});
      check("illegal",   bus.illegal_instr, e.illegal);
      check("mret",      bus.mret_detected, e.mret);
   endtask

   // Drive one cycle of inputs after the falling edge and check before the rise
   task automatic step(input logic [31:0] i, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic we, input logic en);
      @(negedge CLK);
      bus.instr        = i;
      bus.wb_rd        = wrd;
      bus.wb_data      = wd;
      bus.wb_reg_write = we;
      EN               = en;
      #1;
      compare_model();
   endtask

   logic [4:0] opc_tab [10] = '{5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                                5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100};

   function automatic logic [31:0] rand_instr();
      logic [31:0] r = $urandom;
      int sel = $urandom_range(0, 15);
      if (sel < 10) r[6:0] = {opc_tab[sel], 2'b11};
      else if (sel == 10) begin
         r[6:0]   = 7'b0110011;
         r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      else if (sel == 11) r = MRET;
      else if (sel == 12) r[6:0] = 7'b1110011;
      else if (sel == 13) r[6:2] = opc_tab[$urandom_range(0, 9)];
      return r;
   endfunction

   //---------------------------------------------------------------------------
   // Stimulus
   //---------------------------------------------------------------------------
   initial begin
      for (int k = 0; k < 32; k++) model_rf[k] = '0;
      RSTn             = 1'b0;
      EN               = 1'b1;
      bus.instr        = 32'h0050_0033;
      bus.wb_rd        = 5'd5;
      bus.wb_data      = 32'hFFFF_0000;
      bus.wb_reg_write = 1'b1;   // write attempted while in reset must be lost

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RSTn             = 1'b1;
      bus.wb_reg_write = 1'b0;
      #1;
      check("rst_data1", bus.reg_data1, 32'd0);
      check("rst_data2", bus.reg_data2, 32'd0);
      compare_model();

      // x5 write then read back through rs1
      step(32'h0000_0033, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b1);
      step(32'h0002_8033, 5'd5, 32'h0,         1'b0, 1'b1);
      check("x5_read", bus.reg_data1, 32'hDEAD_BEEF);

      // x0 write is ignored
      step(32'h0000_0033, 5'd0, 32'h1, 1'b1, 1'b1);
      step(32'h0000_0033, 5'd0, 32'h1, 1'b0, 1'b1);
      check("x0_read", bus.reg_data1, 32'd0);

      // EN=0 blocks the write
      step(32'h0002_8033, 5'd5, 32'h1111_2222, 1'b1, 1'b0);
      step(32'h0002_8033, 5'd5, 32'h0,         1'b0, 1'b1);
      check("en_block", bus.reg_data1, 32'hDEAD_BEEF);

      // Same-cycle read of a register being written
      step(32'h0000_0033, 5'd7, 32'hA5A5_A5A5, 1'b1, 1'b1);
      step(32'h0070_0033, 5'd7, 32'h1234_5678, 1'b1, 1'b1);
`ifdef RF_WB_BYPASS_EN
      check("bypass_rd2", bus.reg_data2, 32'h1234_5678);
`else
      check("nobypass_rd2", bus.reg_data2, 32'hA5A5_A5A5);
`endif
      step(32'h0070_0033, 5'd7, 32'h0, 1'b0, 1'b1);
      check("after_write_rd2", bus.reg_data2, 32'h1234_5678);

      // addi x2, x2, -4
      step(32'hFFC1_0113, 5'd0, 32'h0, 1'b0, 1'b1);
      check("addi_imm",     bus.imm,           32'hFFFF_FFFC);
      check("addi_rs1",     bus.rs1,           32'd2);
      check("addi_rd",      bus.rd,            32'd2);
      check("addi_rw",      bus.reg_write,     32'd1);
      check("addi_srcb",    bus.alu_src_b,     32'd1);
      check("addi_aluop",   bus.alu_op,        32'd3);
      check("addi_illegal", bus.illegal_instr, 32'd0);

      // lui x1, 0x12345
      step(32'h1234_50B7, 5'd0, 32'h0, 1'b0, 1'b1);
      check("lui_imm", bus.imm,       32'h1234_5000);
      check("lui_rs1", bus.rs1,       32'd0);
      check("lui_rd",  bus.rd,        32'd1);
      check("lui_rw",  bus.reg_write, 32'd1);

      step(MRET, 5'd0, 32'h0, 1'b0, 1'b1);
      check("mret_flag",    bus.mret_detected, 32'd1);
      check("mret_illegal", bus.illegal_instr, 32'd0);
      check("mret_rw",      bus.reg_write,     32'd0);

      step(32'hFFFF_FFFF, 5'd0, 32'h0, 1'b0, 1'b1);
      check("ill_flag", bus.illegal_instr, 32'd1);
      check("ill_rw",   bus.reg_write,     32'd0);
      check("ill_mw",   bus.mem_write,     32'd0);
      check("ill_mr",   bus.mem_read,      32'd0);

      // Asynchronous clear between clock edges
      @(negedge CLK);
      bus.instr = 32'h0002_8033;
      #1;
      check("pre_clear", bus.reg_data1, 32'hDEAD_BEEF);
      RSTn = 1'b0;
      #1;
      check("async_clear", bus.reg_data1, 32'd0);
      check("decode_in_reset", bus.rs1, 32'd5);
      #1;
      RSTn = 1'b1;

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] ri = rand_instr();
         logic [4:0]  wrd = ($urandom_range(0, 3) == 0) ? ri[24:20] : 5'($urandom_range(0, 31));
         step(ri, wrd, $urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
